rf_read_arbiter: RTL
====================

// Module: rf_read_arbiter
// PURPOSE
//  Shares one register-file read port (AW-bit select into the 32:1 mux bank)
//  between NREQ requesters, e.g. fetch/decode operand reads and debug.
//  Round-robin grant, one grant per cycle, 2-stage pipeline: registered
//  select, then registered data. Sits between the requesters and the mux bank.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  AW       5    register address width; mux bank has 2**AW entries
//  DW       64   register data width
//  ZERO_REG 1    1: address 2**AW-1 (X31) returns 0 without using mux data
// PORTS
//  clk        in   1        single clock, all state on posedge
//  reset      in   1        synchronous, active-high
//  req_valid  in   NREQ     requester i has a read pending
//  req_addr   in   NREQ*AW  requester i address at [i*AW +: AW]
//  req_ready  out  NREQ     one-hot grant; handshake = valid[i] & ready[i]
//  stall      in   1        1: issue no new grants (port borrowed for write/test)
//  mux_sel    out  AW       registered select driven into the 32:1 mux bank
//  mux_data   in   DW       combinational mux-bank output for mux_sel
//  rsp_valid  out  NREQ     one-hot, 1 cycle: response for requester i
//  rsp_data   out  DW       read data, valid when any rsp_valid bit is set
//  busy       out  1        a read is in flight (stage 1 or 2 occupied)
// BEHAVIOUR
//  Reset (sync): ptr=0, mux_sel=0, s1_vld=0, s1_id=0, s1_zero=0,
//   rsp_valid=0, rsp_data=0; busy=0 the cycle after. In-flight reads dropped,
//   never answered.
//  Arbitration (combinational, cycle T): if stall=0 and reset=0, grant the
//   first i with req_valid[i]=1, scanning ptr, ptr+1, ... wrapping mod NREQ.
//   req_ready = one-hot of winner, else 0. req_ready never set while
//   req_valid is 0. At most one bit set.
//  Requester holds valid and addr stable until its handshake; dropping
//   valid before the grant is legal and simply cancels.
//  Pointer: on a handshake ptr <= (winner+1) mod NREQ; otherwise holds
//   (including during stall).
//  Stage 1 (T+1): mux_sel <= winner addr; s1_vld<=1; s1_id<=winner;
//   s1_zero <= ZERO_REG & (addr == 2**AW-1). No grant: s1_vld<=0 and
//   mux_sel holds its previous value (no toggling of the mux).
//  Stage 2 (T+2): rsp_valid <= s1_vld ? onehot(s1_id) : 0;
//   rsp_data <= s1_zero ? 0 : mux_data (captured at end of T+1). Holds last
//   value when rsp_valid=0.
//  Latency: handshake at T -> rsp_valid at T+2. Throughput 1 read/cycle,
//   back-to-back grants, no bubbles. No response backpressure.
//  busy = s1_vld | (|rsp_valid).
//  stall: affects only new grants; stages 1-2 drain normally.
//  Reset with a grant in T: no state update; first legal grant is the cycle
//   after reset deasserts, starting from requester 0.
//  Widths: ptr and s1_id are clog2(NREQ) bits; wrap uses explicit compare,
//   not power-of-2 truncation (NREQ need not be 2**k).
// TESTING
//  Bench models mux bank: mux_data = 64'h100 + mux_sel (combinational).
//  1 single: reset; req_valid=0001, addr0=5 -> req_ready=0001 at T,
//    mux_sel=5 at T+1, rsp_valid=0001 and rsp_data=0x105 at T+2, busy=0 at T+3.
//  2 all busy: req_valid=1111 for 8 cycles, addrs 1,2,3,4 -> grants
//    0,1,2,3,0,1,2,3 one per cycle; rsp_data 0x101..0x104 repeating from T+2.
//  3 wrap/fairness: ptr=3 (after a grant to 2), req_valid=0101 -> grant 0,
//    then 2; requester 2 never starved.
//  4 zero reg: ZERO_REG=1, addr=31 -> rsp_data=0; ZERO_REG=0 -> 0x11F.
//  5 stall: grant to 1 at T, stall=1 T+1..T+4 with req_valid=1111 ->
//    req_ready=0 throughout, rsp at T+2 still delivered; stall=0 at T+5 ->
//    grant 2.
//  6 reset mid-flight: grant at T, reset=1 at T+1 -> rsp_valid=0 at T+2,
//    busy=0, next grant goes to requester 0.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
//   Shares one register-file read port between NREQ requesters. A
//   round-robin arbiter issues at most one grant per cycle. The granted
//   address is registered onto mux_sel (stage 1). The mux-bank output is
//   then registered into rsp_data together with a one-hot rsp_valid
//   (stage 2). The response arrives two cycles after the handshake.
//
// Handshake: requester i transfers a read in the cycle where
//   req_valid[i] & req_ready[i] is high. It holds valid/addr stable until
//   then, and it may drop valid earlier to cancel. req_ready is one-hot or
//   zero and is never set without req_valid. Responses have no
//   backpressure: rsp_valid[i] is a single-cycle strobe.
//
// Ports
//   clk, reset   single clock, synchronous active-high reset
//   req_valid    [NREQ]     pending read per requester
//   req_addr     [NREQ*AW]  address of requester i at [i*AW +: AW]
//   req_ready    [NREQ]     one-hot grant (combinational)
//   stall        1          suppress new grants; in-flight reads drain
//   mux_sel      [AW]       registered select into the mux bank
//   mux_data     [DW]       combinational mux-bank output for mux_sel
//   rsp_valid    [NREQ]     one-hot response strobe
//   rsp_data     [DW]       response data, held while rsp_valid is 0
//   busy         1          a read occupies stage 1 or stage 2
module rf_read_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 5,
    parameter int DW       = 64,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    input  logic               stall,
    output logic [AW-1:0]      mux_sel,
    input  logic [DW-1:0]      mux_data,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] TOP_ADDR = {AW{1'b1}};
    localparam logic [PW-1:0] LAST_ID  = PW'(NREQ - 1);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] gnt;
    logic [AW-1:0]   win_addr;

    logic            s1_vld;
    logic [PW-1:0]   s1_id;
    logic            s1_zero;

    // Requester index ptr+k, wrapped by compare so NREQ need not be 2**k.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Scan from ptr upward and take the first requester that is valid.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        if (!stall && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[wrap_add(ptr, k)]) begin
                    found = 1'b1;
                    win   = wrap_add(ptr, k);
                end
            end
        end
        if (found) gnt[win] = 1'b1;
    end

    assign req_ready = gnt;
    assign win_addr  = req_addr[win*AW +: AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            mux_sel   <= '0;
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            s1_zero   <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            s1_vld <= found;
            // With no grant, mux_sel and s1_id hold so that the mux bank stays quiet.
            if (found) begin
                ptr     <= (win == LAST_ID) ? '0 : win + PW'(1);
                mux_sel <= win_addr;
                s1_id   <= win;
                s1_zero <= (ZERO_REG != 0) && (win_addr == TOP_ADDR);
            end
            rsp_valid <= s1_vld ? (NREQ'(1) << s1_id) : '0;
            if (s1_vld) rsp_data <= s1_zero ? '0 : mux_data;
        end
    end

    assign busy = s1_vld | (|rsp_valid);

endmodule
